// File: rtl/fifo_stream_reader.sv
// Purpose : drains a first-word-fall-through FIFO read port into a valid/ready
//           stream through a 2-entry buffer, frames it with m_last and counts beats.
// Latency : a word at the FIFO head with an empty buffer appears on m_valid 1 cycle later.
// Backpressure: fifo_rd_en depends only on registered occupancy, so there is no
//           combinational path from m_ready to it. The second buffer entry absorbs
//           the word that is popped in the cycle m_ready drops.
// Ports   : rclk/rst_n clock and async active-low reset; en/flush control;
//           fifo_rd_en/fifo_rdata/fifo_rempty FIFO read side;
//           m_data/m_valid/m_last/m_ready output stream; beat_count delivered beats.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  flush,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_rempty,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  beat_count
);

  localparam int               IDX_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  push;
  logic                  pop;

  // rst_n in the term keeps the pop strobe low for the whole reset window,
  // not just from the first edge after reset asserts.
  assign fifo_rd_en = rst_n & en & ~flush & ~fifo_rempty & (state != S_TWO);
  assign push       = fifo_rd_en;
  assign pop        = m_valid & m_ready;

  assign m_valid = (state != S_EMPTY);
  assign m_data  = head_q;
  assign m_last  = m_valid & (idx_q == IDX_LAST);

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      idx_q      <= '0;
      beat_count <= '0;
    end else begin
      // A handshake in the flush cycle really happened downstream, so it is counted.
      if (pop) beat_count <= beat_count + CNT_WIDTH'(1);

      if (flush) begin
        state <= S_EMPTY;
        idx_q <= '0;
      end else begin
        if (pop) idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

        unique case (state)
          S_EMPTY: begin
            if (push) begin
              head_q <= fifo_rdata;
              state  <= S_ONE;
            end
          end
          S_ONE: begin
            if (push && pop) begin
              head_q <= fifo_rdata;        // streaming: new word replaces the one leaving
            end else if (push) begin
              tail_q <= fifo_rdata;
              state  <= S_TWO;
            end else if (pop) begin
              state  <= S_EMPTY;
            end
          end
          S_TWO: begin
            // fifo_rd_en is low in this state, so only a pop can change it
            if (pop) begin
              head_q <= tail_q;
              state  <= S_ONE;
            end
          end
          default: state <= S_EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader (BURST_LEN=4, CNT_WIDTH=8 so framing and counter wrap
// are reachable). The FIFO is a queue; the expected buffer is a queue of at most two
// words that the bench fills and drains from the visible push/pop rules.
module tb_fifo_stream_reader;
  localparam int DW = 32;
  localparam int BL = 4;
  localparam int CW = 8;

  logic          rclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic          m_ready = 1'b0;
  logic          fifo_rempty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic [CW-1:0] beat_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo_q[$];     // external FIFO contents
  logic [DW-1:0] mbuf[$];       // expected output buffer contents, head first
  int            mpos  = 0;     // beats delivered since frame start, mod BL
  int            mbeats = 0;    // beats delivered since reset
  logic          exp_push, exp_pop, exp_flush, exp_rst;
  logic [DW-1:0] dlog[$];       // delivered words
  logic          llog[$];       // m_last seen with each delivered word
  logic [DW-1:0] wr_hist[$];

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(CW)) dut (
    .rclk(rclk), .rst_n(rst_n), .en(en), .flush(flush),
    .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .beat_count(beat_count)
  );

  always #5 rclk = ~rclk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sync_fifo();
    fifo_rempty = (fifo_q.size() == 0);
    fifo_rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEAD_BEEF;
  endtask

  task automatic fifo_write(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    sync_fifo();
  endtask

  // Compare every cycle at the falling edge, then apply the expected state change.
  task automatic tick();
    logic ev, el, er;
    @(negedge rclk);
    if (!rst_n) begin
      mbuf.delete();
      mpos   = 0;
      mbeats = 0;
    end
    er = rst_n && en && !flush && (fifo_q.size() > 0) && (mbuf.size() < 2);
    ev = (mbuf.size() > 0);
    el = ev && (mpos == BL - 1);
    chk("fifo_rd_en", fifo_rd_en, er);
    chk("rd_en_while_empty", fifo_rd_en & fifo_rempty, 0);
    chk("m_valid", m_valid, ev);
    chk("m_last", m_last, el);
    if (ev) chk("m_data", m_data, mbuf[0]);
    chk("beat_count", beat_count, mbeats % (1 << CW));
    exp_push  = er;
    exp_pop   = ev && m_ready;
    exp_flush = flush;
    exp_rst   = !rst_n;
    if (exp_pop) begin
      dlog.push_back(mbuf[0]);
      llog.push_back(el);
    end
    @(posedge rclk);
    #1;
    if (!exp_rst) begin
      if (exp_pop) begin
        void'(mbuf.pop_front());
        mbeats++;
        mpos = (mpos + 1) % BL;
      end
      if (exp_push) mbuf.push_back(fifo_q.pop_front());
      if (exp_flush) begin
        mbuf.delete();
        mpos = 0;
      end
    end
    sync_fifo();
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((fifo_q.size() > 0 || mbuf.size() > 0) && n < max_cyc) begin
      tick();
      n++;
    end
    chk("drain_within_budget", (fifo_q.size() > 0 || mbuf.size() > 0), 0);
  endtask

  initial begin
    int bad;
    int pulses;
    logic [DW-1:0] w;
    sync_fifo();

    // Reset: a word sits in the FIFO but nothing may be popped.
    en = 1'b1;
    fifo_write(32'h0000_DEAD);
    tick();
    tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_beat_count", beat_count, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    fifo_q.delete();
    sync_fifo();
    rst_n = 1'b1;
    tick();

    // 1: A0..A3 stream straight through.
    m_ready = 1'b1;
    dlog.delete();
    for (int i = 0; i < 4; i++) fifo_write(32'hA0 + i);
    #1;
    chk("t1_valid_before", m_valid, 0);
    tick();
    chk("t1_valid_1cyc", m_valid, 1);
    chk("t1_first_word", m_data, 32'hA0);
    repeat (4) tick();
    chk("t1_beat_count", beat_count, 4);
    chk("t1_count", dlog.size(), 4);
    for (int i = 0; i < 4; i++) chk("t1_word", dlog[i], 32'hA0 + i);

    // 2: backpressure fills the buffer, then everything is delivered in order.
    m_ready = 1'b0;
    dlog.delete();
    for (int i = 0; i < 5; i++) fifo_write(32'hB0 + i);
    repeat (4) tick();
    chk("t2_fifo_left", fifo_q.size(), 3);
    chk("t2_rd_en_off", fifo_rd_en, 0);
    chk("t2_head", m_data, 32'hB0);
    chk("t2_valid", m_valid, 1);
    m_ready = 1'b1;
    drain(50);
    chk("t2_count", dlog.size(), 5);
    for (int i = 0; i < 5; i++) chk("t2_word", dlog[i], 32'hB0 + i);

    // 3: framing with BURST_LEN=4; restart the frame with a flush first.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    llog.delete();
    for (int i = 0; i < 10; i++) fifo_write(32'hC0 + i);
    drain(50);
    chk("t3_count", llog.size(), 10);
    for (int i = 0; i < 10; i++) chk("t3_last", llog[i], (i == 3 || i == 7));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    llog.delete();
    for (int i = 0; i < 5; i++) fifo_write(32'hC8 + i);
    drain(50);
    for (int i = 0; i < 5; i++) chk("t3_last_post_flush", llog[i], (i == 3));
    chk("t3_beat_count", beat_count, 24);

    // 5: flush in state TWO with no handshake discards both words.
    m_ready = 1'b0;
    dlog.delete();
    for (int i = 0; i < 3; i++) fifo_write(32'hD0 + i);
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_valid_dropped", m_valid, 0);
    chk("t5_beat_count", beat_count, 24);
    m_ready = 1'b1;
    drain(20);
    chk("t5_count", dlog.size(), 1);
    chk("t5_next_word", dlog[0], 32'hD2);
    // flush coinciding with a handshake still counts that beat
    m_ready = 1'b0;
    fifo_write(32'hE0);
    fifo_write(32'hE1);
    repeat (3) tick();
    m_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_flush_pop_count", beat_count, 26);
    chk("t5_flush_pop_valid", m_valid, 0);

    // 4: random fill and backpressure; order and count preserved, counter wraps.
    dlog.delete();
    for (int cyc = 0; cyc < 40000 && dlog.size() < 10000; cyc++) begin
      if (fifo_q.size() < 6 && $urandom_range(0, 2) != 0) begin
        w = $urandom;
        wr_hist.push_back(w);
        fifo_write(w);
      end
      m_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    chk("t4_beats_reached", (dlog.size() >= 10000), 1);
    m_ready = 1'b1;
    drain(50);
    chk("t4_total", dlog.size(), wr_hist.size());
    bad = 0;
    for (int i = 0; i < dlog.size() && i < wr_hist.size(); i++)
      if (dlog[i] !== wr_hist[i]) bad++;
    chk("t4_order", bad, 0);
    chk("t4_beat_wrap", beat_count, (26 + wr_hist.size()) % (1 << CW));

    // 6: async reset with the buffer full, then en=0 drain.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) fifo_write(32'hF0 + i);
    repeat (3) tick();
    chk("t6_full_before_rst", m_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", m_valid, 0);
    chk("t6_rst_last", m_last, 0);
    chk("t6_rst_rd_en", fifo_rd_en, 0);
    chk("t6_rst_count", beat_count, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    fifo_write(32'h60);
    en = 1'b0;
    m_ready = 1'b1;
    dlog.delete();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      pulses += fifo_rd_en;
      tick();
    end
    chk("t6_no_rd_en_when_disabled", pulses, 0);
    chk("t6_drain_count", dlog.size(), 2);
    chk("t6_drain_w0", dlog[0], 32'hF2);
    chk("t6_drain_w1", dlog[1], 32'hF3);
    chk("t6_fifo_untouched", fifo_q.size(), 1);
    chk("t6_idle", m_valid, 0);
    chk("t6_beat_count", beat_count, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
